exec_unit: RTL and testbench

Execute-stage ALU that consumes the second operand chosen by the operand-select mux: rt data, 16-bit extended immediate or 11-bit extended field.
- Single-cycle logic/arithmetic/shift operations complete in 1 cycle.
- Unsigned multiply and unsigned divide run as iterative 32-step sequences behind a start/busy/done handshake.
- Results are registered and held for writeback and hazard logic.

---
 rtl/exec_unit.sv | 174 +++++++++++++++++
 tb/tb_exec_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus iterative
// unsigned multiply/divide behind a start/busy/done handshake.
module exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             divzero,
    output logic             busy,
    output logic             done
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,
                           OP_OR  = 4'd3,  OP_XOR = 4'd4,  OP_NOR = 4'd5,
                           OP_SLT = 4'd6,  OP_SLL = 4'd7,  OP_SRL = 4'd8,
                           OP_SRA = 4'd9,  OP_MUL = 4'd10, OP_DIV = 4'd11;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dvs, r_hw, r_lw;
    logic [WIDTH-1:0] r_result, r_hi;
    logic             r_zero, r_ovf, r_dz, r_done;

    logic [WIDTH-1:0] w_sc_res, w_sc_hi, w_sum, w_diff;
    logic             w_sc_ovf, w_sc_dz, w_last;
    logic [WIDTH:0]   w_mul_sum, w_div_shr, w_div_diff;
    logic [WIDTH-1:0] w_mul_hi, w_mul_lo, w_div_rem, w_div_quo;

    assign w_sum  = a + b;
    assign w_diff = a - b;
    assign w_last = (r_cnt == LAST);

    always_comb begin
        w_sc_res = '0;
        w_sc_hi  = '0;
        w_sc_ovf = 1'b0;
        w_sc_dz  = 1'b0;
        case (op)
            OP_ADD: begin
                w_sc_res = w_sum;
                w_sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_sc_res = w_diff;
                w_sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: w_sc_res = a & b;
            OP_OR:  w_sc_res = a | b;
            OP_XOR: w_sc_res = a ^ b;
            OP_NOR: w_sc_res = ~(a | b);
            OP_SLT: w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL: w_sc_res = a << b[SHW-1:0];
            OP_SRL: w_sc_res = a >> b[SHW-1:0];
            OP_SRA: w_sc_res = $unsigned($signed(a) >>> b[SHW-1:0]);
            OP_DIV: begin
                // Only reached for a zero divisor; nonzero divisors go iterative
                w_sc_res = '1;
                w_sc_hi  = a;
                w_sc_dz  = 1'b1;
            end
            default: ;
        endcase
    end

    // Shared hi/lo pair: shift-add multiply shifts right, restoring divide shifts left
    always_comb begin
        w_mul_sum  = {1'b0, r_hw} + (r_lw[0] ? {1'b0, r_dvs} : '0);
        w_mul_hi   = w_mul_sum[WIDTH:1];
        w_mul_lo   = {w_mul_sum[0], r_lw[WIDTH-1:1]};
        w_div_shr  = {r_hw, r_lw[WIDTH-1]};
        w_div_diff = w_div_shr - {1'b0, r_dvs};
        w_div_rem  = w_div_diff[WIDTH] ? w_div_shr[WIDTH-1:0] : w_div_diff[WIDTH-1:0];
        w_div_quo  = {r_lw[WIDTH-2:0], ~w_div_diff[WIDTH]};
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && op == OP_MUL)                 w_next = S_MUL;
                else if (start && op == OP_DIV && b != '0) w_next = S_DIV;
            end
            S_MUL, S_DIV: if (w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_dvs    <= '0;
            r_hw     <= '0;
            r_lw     <= '0;
            r_result <= '0;
            r_hi     <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
            r_dz     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    if (op == OP_MUL || (op == OP_DIV && b != '0)) begin
                        r_dvs <= b;
                        r_lw  <= a;
                        r_hw  <= '0;
                        r_cnt <= '0;
                    end else begin
                        r_result <= w_sc_res;
                        r_hi     <= w_sc_hi;
                        r_zero   <= (w_sc_res == '0);
                        r_ovf    <= w_sc_ovf;
                        r_dz     <= w_sc_dz;
                        r_done   <= 1'b1;
                    end
                end
                S_MUL: begin
                    r_hw  <= w_mul_hi;
                    r_lw  <= w_mul_lo;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= w_mul_lo;
                        r_hi     <= w_mul_hi;
                        r_zero   <= (w_mul_lo == '0);
                        r_ovf    <= 1'b0;
                        r_dz     <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                S_DIV: begin
                    r_hw  <= w_div_rem;
                    r_lw  <= w_div_quo;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= w_div_quo;
                        r_hi     <= w_div_rem;
                        r_zero   <= (w_div_quo == '0);
                        r_ovf    <= 1'b0;
                        r_dz     <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result   = r_result;
    assign hi       = r_hi;
    assign zero     = r_zero;
    assign overflow = r_ovf;
    assign divzero  = r_dz;
    assign done     = r_done;
    assign busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: single-cycle vector table plus hand-written
// multiply/divide, ignored-start and reset-abort sequences.
module tb_exec_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic [W-1:0] result, hi;
    logic         zero, overflow, divzero, busy, done;

    int n_checks = 0;
    int n_errors = 0;

    exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .result(result), .hi(hi), .zero(zero), .overflow(overflow),
        .divzero(divzero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [31:0] a, b, res, hi;
        logic       z, ovf, dz, chk_z;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".result"}, 64'(result), 64'h0);
        chk({tag, ".hi"}, 64'(hi), 64'h0);
        chk({tag, ".zero"}, 64'(zero), 64'h1);
        chk({tag, ".ovf"}, 64'(overflow), 64'h0);
        chk({tag, ".divzero"}, 64'(divzero), 64'h0);
        chk({tag, ".busy"}, 64'(busy), 64'h0);
        chk({tag, ".done"}, 64'(done), 64'h0);
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
    endtask

    initial begin
        int cyc;
        bit seen;

        //             name        op     a             b             result        hi            z  ovf dz chkz
        vecs[0]  = '{"add_ovf",  4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        0, 1, 0, 1};
        vecs[1]  = '{"sub_eq",   4'd1,  32'd5,        32'd5,        32'h0,        32'h0,        1, 0, 0, 1};
        vecs[2]  = '{"slt_neg",  4'd6,  32'hFFFFFFFF, 32'h00000001, 32'h1,        32'h0,        0, 0, 0, 1};
        vecs[3]  = '{"slt_pos",  4'd6,  32'h00000001, 32'hFFFFFFFF, 32'h0,        32'h0,        1, 0, 0, 1};
        vecs[4]  = '{"sra_31",   4'd9,  32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 32'h0,        0, 0, 0, 1};
        vecs[5]  = '{"sll_mask", 4'd7,  32'h00000001, 32'h00000024, 32'h00000010, 32'h0,        0, 0, 0, 1};
        vecs[6]  = '{"srl_4",    4'd8,  32'h80000000, 32'h00000004, 32'h08000000, 32'h0,        0, 0, 0, 1};
        vecs[7]  = '{"and",      4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0,        0, 0, 0, 1};
        vecs[8]  = '{"or",       4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'h0,        0, 0, 0, 1};
        vecs[9]  = '{"xor",      4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0,        0, 0, 0, 1};
        vecs[10] = '{"nor",      4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 32'h0,        0, 0, 0, 1};
        vecs[11] = '{"sub_ovf",  4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0,        0, 1, 0, 1};
        vecs[12] = '{"divu_z",   4'd11, 32'd9,        32'd0,        32'hFFFFFFFF, 32'd9,        0, 0, 1, 1};
        vecs[13] = '{"add_hi0",  4'd0,  32'd2,        32'd3,        32'd5,        32'h0,        0, 0, 0, 1};
        vecs[14] = '{"op_rsvd",  4'd13, 32'd5,        32'd5,        32'h0,        32'h0,        1, 0, 0, 0};

        reset = 1'b1;
        tick();
        tick();
        chk_reset_state("rst");
        reset = 1'b0;
        tick();
        chk("idle.done", 64'(done), 64'h0);

        // Back-to-back: a new start every cycle, done must stay high
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            tick();
            start = 1'b0;
            chk({vecs[i].name, ".result"}, 64'(result), 64'(vecs[i].res));
            chk({vecs[i].name, ".hi"}, 64'(hi), 64'(vecs[i].hi));
            if (vecs[i].chk_z) chk({vecs[i].name, ".zero"}, 64'(zero), 64'(vecs[i].z));
            chk({vecs[i].name, ".ovf"}, 64'(overflow), 64'(vecs[i].ovf));
            chk({vecs[i].name, ".divzero"}, 64'(divzero), 64'(vecs[i].dz));
            chk({vecs[i].name, ".done"}, 64'(done), 64'h1);
            chk({vecs[i].name, ".busy"}, 64'(busy), 64'h0);
        end
        tick();
        chk("b2b.done_drop", 64'(done), 64'h0);
        chk("b2b.hold", 64'(result), 64'h0);

        // MULTU max*max with a start and operand churn mid-sequence
        issue(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tick();
        start = 1'b0;
        chk("mul.busy_rise", 64'(busy), 64'h1);
        chk("mul.done_lo", 64'(done), 64'h0);
        cyc = 0;
        seen = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) issue(4'd0, 32'd1, 32'd1);
            else begin
                start = 1'b0;
                a = 32'h12345678;
                b = 32'h0;
            end
            tick();
            if (done) begin
                cyc = k;
                seen = 1;
                break;
            end
        end
        start = 1'b0;
        chk("mul.seen_done", 64'(seen), 64'h1);
        chk("mul.cycles", 64'(cyc), 64'd32);
        chk("mul.hi", 64'(hi), 64'hFFFFFFFE);
        chk("mul.result", 64'(result), 64'h1);
        chk("mul.zero", 64'(zero), 64'h0);
        chk("mul.busy_fall", 64'(busy), 64'h0);
        tick();
        chk("mul.done_pulse", 64'(done), 64'h0);
        chk("mul.hold", 64'(result), 64'h1);

        // DIVU 100/7 with a start on the finishing edge, which must be dropped
        issue(4'd11, 32'd100, 32'd7);
        tick();
        chk("div.busy_rise", 64'(busy), 64'h1);
        cyc = 0;
        seen = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 32) issue(4'd0, 32'd1, 32'd1);
            else start = 1'b0;
            tick();
            if (done) begin
                cyc = k;
                seen = 1;
                break;
            end
        end
        start = 1'b0;
        chk("div.seen_done", 64'(seen), 64'h1);
        chk("div.cycles", 64'(cyc), 64'd32);
        chk("div.quot", 64'(result), 64'd14);
        chk("div.rem", 64'(hi), 64'd2);
        chk("div.divzero", 64'(divzero), 64'h0);
        tick();
        chk("div.late_start_ign", 64'(done), 64'h0);
        chk("div.hold", 64'(result), 64'd14);

        // Reset mid-multiply: aborts with no done pulse
        issue(4'd10, 32'd3, 32'd4);
        tick();
        start = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_state("abort");
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done || busy) seen = 1;
        end
        chk("abort.no_done", 64'(seen), 64'h0);
        issue(4'd0, 32'd2, 32'd3);
        tick();
        start = 1'b0;
        chk("post.add", 64'(result), 64'd5);
        chk("post.done", 64'(done), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
